dmem_mmio: RTL and testbench

Data-memory and memory-mapped I/O block sitting directly downstream of the pipelined core's memory stage. It takes the core's M-stage store strobe, address and store data, and returns load data combinationally in the same cycle. The address space is decoded into word RAM plus four I/O registers: LED output, free-running cycle counter, UART transmit data and UART status. Transmit data is queued in a small FIFO and serialised 8N1 on a single output line.

---
 rtl/dmem_mmio_pkg.sv | 27 ++
 rtl/dmem_mmio_uart_tx.sv | 156 +++++++++++++++
 rtl/dmem_mmio.sv | 103 ++++++++++
 tb/tb_dmem_mmio.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO block: I/O register addresses,
// STATUS bit positions and UART transmitter state encoding.
package dmem_mmio_pkg;

    localparam logic [31:0] ADDR_LED    = 32'h8000_0000;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_000C;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Word-granular address match: the two byte-offset bits never take part.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        return (addr & ~32'h3) == base;
    endfunction

endpackage

// File: rtl/dmem_mmio_uart_tx.sv
// UART transmitter: small byte FIFO feeding an 8N1 serialiser, with a sticky
// overflow flag for pushes that arrive while the FIFO is full.
module dmem_mmio_uart_tx
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       ovf_clr,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic       uart_tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    tx_state_t     state;
    tx_state_t     state_d;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_d;
    logic [7:0]    shreg;
    logic [7:0]    shreg_d;
    logic          tx_q;
    logic          tx_d;
    logic          pop;
    logic          push_ok;
    logic          baud_done;

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != TX_IDLE);
    assign uart_tx   = tx_q;
    assign push_ok   = push && !full;
    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // A pop never frees room for a push in the same cycle: fullness is judged
    // on the count before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_clr) begin
                ovf <= 1'b0;
            end else if (push && full) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shreg    <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    // The line level is registered from the next state so each bit appears
    // exactly on the edge the FSM enters it.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shreg_d = shreg;
        pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_mem[rd_ptr];
                    baud_d  = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_idx + 1'b1;
                        shreg_d = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory plus memory-mapped LED, cycle counter and UART registers behind
// the core's M stage; loads are answered combinationally in the same cycle.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int MEM_WORDS    = 64,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   cycle;
    logic [AW-1:0] ram_idx;
    logic          is_ram;
    logic          hit_led;
    logic          hit_cycle;
    logic          hit_txdata;
    logic          hit_status;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_busy;
    logic          tx_ovf;
    logic [31:0]   status_word;

    assign is_ram     = (a < 32'(MEM_WORDS * 4));
    assign ram_idx    = a[AW+1:2];
    assign hit_led    = addr_hit(a, ADDR_LED);
    assign hit_cycle  = addr_hit(a, ADDR_CYCLE);
    assign hit_txdata = addr_hit(a, ADDR_TXDATA);
    assign hit_status = addr_hit(a, ADDR_STATUS);

    // RAM keeps its contents across reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (we && is_ram) begin
            ram[ram_idx] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds  <= '0;
            cycle <= '0;
        end else begin
            if (we && hit_led) begin
                leds <= wd[7:0];
            end
            if (we && hit_cycle) begin
                cycle <= wd;
            end else begin
                cycle <= cycle + 32'd1;
            end
        end
    end

    dmem_mmio_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .push     (we && hit_txdata),
        .push_data(wd[7:0]),
        .ovf_clr  (we && hit_status),
        .full     (tx_full),
        .empty    (tx_empty),
        .busy     (tx_busy),
        .ovf      (tx_ovf),
        .uart_tx  (uart_tx)
    );

    always_comb begin
        status_word             = '0;
        status_word[STAT_FULL]  = tx_full;
        status_word[STAT_EMPTY] = tx_empty;
        status_word[STAT_BUSY]  = tx_busy;
        status_word[STAT_OVF]   = tx_ovf;
    end

    always_comb begin
        rd = '0;
        if (is_ram) begin
            rd = ram[ram_idx];
        end else if (hit_led) begin
            rd = {24'b0, leds};
        end else if (hit_cycle) begin
            rd = cycle;
        end else if (hit_status) begin
            rd = status_word;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus random traffic,
// all compared against a frame-level behavioural model of memory and UART.
module tb_dmem_mmio;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int WORDS = 64;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        uart_tx;

    int total = 0;
    int bad   = 0;

    logic [31:0] obs_rd;
    logic        obs_tx;
    logic [7:0]  obs_leds;

    // Behavioural model: RAM array, registers, byte queue and frame position.
    logic [31:0] m_ram   [WORDS];
    bit          m_known [WORDS];
    logic [7:0]  m_leds;
    logic [31:0] m_cycle;
    logic [7:0]  m_q[$];
    bit          m_ovf;
    int          m_pos;
    logic [7:0]  m_cur;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    dmem_mmio #(
        .MEM_WORDS   (WORDS),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .a      (a),
        .wd     (wd),
        .rd     (rd),
        .leds   (leds),
        .uart_tx(uart_tx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRd(input logic [31:0] addr, output bit known);
        logic [31:0] wa;
        int          idx;
        wa    = addr & ~32'h3;
        known = 1'b1;
        if (addr < WORDS * 4) begin
            idx   = int'(addr) / 4;
            known = m_known[idx];
            return m_ram[idx];
        end
        case (wa)
            A_LED:    return {24'b0, m_leds};
            A_CYCLE:  return m_cycle;
            A_STATUS: return {28'b0, m_ovf, (m_pos >= 0), (m_q.size() == 0), (m_q.size() == DEPTH)};
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic modelTx();
        if (m_pos < 0)     return 1'b1;
        if (m_pos < C)     return 1'b0;
        if (m_pos < 9 * C) return m_cur[(m_pos / C) - 1];
        return 1'b1;
    endfunction

    task automatic modelStep(input bit rst, input bit w, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] wa;
        bit          was_full;
        wa = addr & ~32'h3;
        if (rst) begin
            m_leds  = 8'h0;
            m_cycle = 32'h0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_pos   = -1;
            m_valid = 1'b1;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        if (m_pos < 0) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == 10 * C) m_pos = -1;
        end
        m_cycle = (w && wa == A_CYCLE) ? data : m_cycle + 32'd1;
        if (w) begin
            if (addr < WORDS * 4) begin
                m_ram[int'(addr) / 4]   = data;
                m_known[int'(addr) / 4] = 1'b1;
            end else if (wa == A_LED) begin
                m_leds = data[7:0];
            end else if (wa == A_TXDATA) begin
                if (was_full) m_ovf = 1'b1;
                else          m_q.push_back(data[7:0]);
            end else if (wa == A_STATUS) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    // One bus cycle: drive, check settled outputs against the model, clock.
    task automatic applyStimulus(input bit rst, input bit w, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] exp;
        bit          known;
        reset = rst;
        we    = w;
        a     = addr;
        wd    = data;
        #2;
        obs_rd   = rd;
        obs_tx   = uart_tx;
        obs_leds = leds;
        if (m_valid) begin
            exp = modelRd(addr, known);
            if (known) checkOutput("rd", rd, exp);
            checkOutput("leds", {24'b0, leds}, {24'b0, m_leds});
            checkOutput("uart_tx", {31'b0, uart_tx}, {31'b0, modelTx()});
        end
        @(posedge clk);
        modelStep(rst, w, addr, data);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((m_pos >= 0 || m_q.size() != 0) && n < 1000) begin
            applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
            n++;
        end
        applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
        checkOutput(tag, obs_rd & 32'h6, 32'h2);
    endtask

    initial begin
        logic [31:0] exp_busy;
        logic        exp_tx;
        logic [31:0] addr;
        int          kind;

        reset = 1'b1;
        we    = 1'b0;
        a     = A_STATUS;
        wd    = 32'h0;
        for (int i = 0; i < WORDS; i++) m_known[i] = 1'b0;

        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        applyStimulus(1'b0, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_reset", obs_rd, 32'h0);
        checkOutput("tx_reset", {31'b0, obs_tx}, 32'h1);
        applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
        checkOutput("status_reset", obs_rd, 32'h2);
        checkOutput("leds_reset", {24'b0, obs_leds}, 32'h0);

        for (int i = 0; i < WORDS; i++) applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 32'h14, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
        checkOutput("ram_0x10", obs_rd, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 32'h13, 32'h0);
        checkOutput("ram_0x13", obs_rd, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 32'h14, 32'h0);
        checkOutput("ram_0x14", obs_rd, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 32'h4000_0000, 32'h0);
        checkOutput("unmapped", obs_rd, 32'h0);

        applyStimulus(1'b0, 1'b1, A_LED, 32'h1A5);
        applyStimulus(1'b0, 1'b0, A_LED, 32'h0);
        checkOutput("led_rd", obs_rd, 32'hA5);
        checkOutput("led_port", {24'b0, obs_leds}, 32'hA5);

        applyStimulus(1'b0, 1'b1, A_CYCLE, 32'h100);
        applyStimulus(1'b0, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_load", obs_rd, 32'h100);
        applyStimulus(1'b0, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_inc", obs_rd, 32'h101);
        applyStimulus(1'b0, 1'b1, A_CYCLE, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_max", obs_rd, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, A_CYCLE, 32'h0);
        checkOutput("cycle_wrap", obs_rd, 32'h0);

        // Single 0x55 frame, timed from the write cycle (cycle 0).
        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'h55);
        for (int cyc = 1; cyc <= 44; cyc++) begin
            applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
            if (cyc >= 2 && cyc <= 5)        exp_tx = 1'b0;
            else if (cyc >= 6 && cyc <= 37)  exp_tx = ((8'h55 >> ((cyc - 6) / 4)) & 8'h1) != 0;
            else                             exp_tx = 1'b1;
            exp_busy = (cyc >= 2 && cyc <= 41) ? 32'h1 : 32'h0;
            checkOutput("frame55_tx", {31'b0, obs_tx}, {31'b0, exp_tx});
            checkOutput("frame55_busy", (obs_rd >> 2) & 32'h1, exp_busy);
        end

        // Burst of six pushes: one popped straight away, four fill, sixth dropped.
        waitIdle("idle_before_burst");
        for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, A_TXDATA, 32'(i));
        applyStimulus(1'b0, 1'b1, A_STATUS, 32'hFFFF_FFFF);
        checkOutput("status_ovf", obs_rd, 32'hD);
        applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
        checkOutput("status_ovf_clr", obs_rd, 32'h5);
        waitIdle("idle_after_burst");

        // Reset in the middle of a 0xFF frame.
        applyStimulus(1'b0, 1'b1, A_TXDATA, 32'hFF);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
        applyStimulus(1'b1, 1'b0, A_STATUS, 32'h0);
        applyStimulus(1'b0, 1'b0, A_CYCLE, 32'h0);
        checkOutput("rst_cycle", obs_rd, 32'h0);
        checkOutput("rst_tx", {31'b0, obs_tx}, 32'h1);
        checkOutput("rst_leds", {24'b0, obs_leds}, 32'h0);
        applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0);
        checkOutput("rst_status", obs_rd, 32'h2);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
        checkOutput("rst_ram_kept", obs_rd, 32'hDEAD_BEEF);

        // Random traffic across every region, with occasional resets.
        for (int n = 0; n < 900; n++) begin
            kind = $urandom_range(0, 11);
            case (kind)
                0, 1, 2: addr = $urandom_range(0, WORDS * 4 - 1);
                3:       addr = A_LED | $urandom_range(0, 3);
                4:       addr = A_CYCLE;
                5, 6:    addr = A_TXDATA;
                7:       addr = A_STATUS;
                8:       addr = 32'h8000_0010 + $urandom_range(0, 31);
                default: addr = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
            endcase
            if ($urandom_range(0, 199) == 0) applyStimulus(1'b1, 1'b0, addr, $urandom);
            else applyStimulus(1'b0, ($urandom_range(0, 2) == 0), addr, $urandom);
        end
        waitIdle("idle_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
